fmul_sched: RTL

//  Issue scheduler for the shared pipelined FP multiplier (unpack/Wallace stage -> add -> normalise).

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fmul_sched_rr_arb2.sv | 37 +++
 rtl/fmul_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants for the FP multiply issue path: pipeline depth, tag width,
// requester ids and a handy 1.0f operand.
package fpu_pkg;

  localparam int          FMUL_STAGES = 3;
  localparam int          TAGW        = 5;
  localparam logic        SRC_INT     = 1'b0;
  localparam logic        SRC_DIV     = 1'b1;
  localparam logic [31:0] FP_ONE      = 32'h3f800000;

endpackage

// File: rtl/fmul_sched_rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer moves to the losing side
// only when a grant is actually taken by the pipeline.
module rr_arb2 (
  input  logic       clk,
  input  logic       clrn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Granting side 0 hands priority to side 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fmul_sched.sv
// Issue scheduler for the shared pipelined FP multiplier: arbitration, operand
// register, per-stage valid/source/tag tracking and a single global stall.
module fmul_sched #(
  parameter int STAGES = fpu_pkg::FMUL_STAGES,
  parameter int TAGW   = fpu_pkg::TAGW
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            flush,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [31:0]     r0_a,
  input  logic [31:0]     r0_b,
  input  logic [TAGW-1:0] r0_tag,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [31:0]     r1_a,
  input  logic [31:0]     r1_b,
  input  logic [TAGW-1:0] r1_tag,
  output logic [31:0]     op_a,
  output logic [31:0]     op_b,
  output logic            adv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_src,
  output logic [TAGW-1:0] out_tag,
  output logic [1:0]      busy
);

  import fpu_pkg::*;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  logic              take;
  logic              win_src;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] src_q, src_d;
  logic [TAGW-1:0]   tag_q [STAGES];
  logic [TAGW-1:0]   tag_d [STAGES];
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [7:0]        busy_cnt;

  // The whole pipe advances together; only a held result in the last stage stalls it.
  assign adv     = ~v_q[STAGES-1] | out_ready;
  assign accept  = adv & ~flush;
  assign req     = {r1_valid, r0_valid};
  assign take    = accept & (|gnt);
  assign win_src = gnt[1] ? SRC_DIV : SRC_INT;

  rr_arb2 u_arb (
    .clk    (clk),
    .clrn   (clrn),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign r0_ready = gnt[0] & accept;
  assign r1_ready = gnt[1] & accept;

  assign v_d[0]   = flush ? 1'b0 : (adv ? take : v_q[0]);
  assign src_d[0] = take ? win_src : src_q[0];
  assign tag_d[0] = take ? (gnt[1] ? r1_tag : r0_tag) : tag_q[0];
  assign op_a_d   = take ? (gnt[1] ? r1_a : r0_a) : op_a_q;
  assign op_b_d   = take ? (gnt[1] ? r1_b : r0_b) : op_b_q;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      assign v_d[gi]   = flush ? 1'b0 : (adv ? v_q[gi-1] : v_q[gi]);
      assign src_d[gi] = adv ? src_q[gi-1] : src_q[gi];
      assign tag_d[gi] = adv ? tag_q[gi-1] : tag_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q    <= '0;
      src_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      src_q  <= src_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      busy_cnt = busy_cnt + {7'd0, v_q[i]};
    end
    busy = (busy_cnt > 8'd3) ? 2'd3 : busy_cnt[1:0];
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_valid = v_q[STAGES-1];
  assign out_src   = src_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule
